// File: rtl/timing_sequencer.sv
// Master timing controller for the four-phase clock drivers: power-up, run/halt/step sequencing and W/X/Y/Z generator patterns.
// Optional driver-feedback phase monitor is enabled by defining PHASE_MON_EN.
module timing_sequencer #(
  parameter int PHASE_CYCLES   = 2,
  parameter int BITS_PER_WORD  = 14,
  parameter int STARTUP_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic       RUN_REQ,
  input  logic       STEP,
`ifdef PHASE_MON_EN
  input  logic [3:0] PH_FB,
  output logic       CLK_FAULT,
`endif
  output logic       BOP,
  output logic       CGPP,
  output logic       CGPPN,
  output logic       CGQP,
  output logic       CGQPN,
  output logic       CGRP,
  output logic       CGRPN,
  output logic [1:0] PHASE,
  output logic [3:0] BIT_TIME,
  output logic       WORD_END,
  output logic       RUNNING,
  output logic       HALTED
);

  localparam int PCW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam int WCW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;
  localparam logic [PCW-1:0] PC_LAST  = PCW'(PHASE_CYCLES - 1);
  localparam logic [WCW-1:0] WC_LAST  = WCW'(STARTUP_CYCLES - 1);
  localparam logic [3:0]     BIT_LAST = 4'(BITS_PER_WORD - 1);

  typedef enum logic [1:0] {S_OFF, S_WARMUP, S_HALT, S_RUN} state_t;

  // {P,Q,R} generator pattern for each phase
  function automatic logic [2:0] f_pattern(input logic [1:0] ph);
    case (ph)
      2'd0:    f_pattern = 3'b101;
      2'd1:    f_pattern = 3'b011;
      2'd2:    f_pattern = 3'b110;
      default: f_pattern = 3'b000;
    endcase
  endfunction

  state_t           r_state, w_state_nx;
  logic [PCW-1:0]   r_pcnt, w_pcnt_nx;
  logic [WCW-1:0]   r_wcnt, w_wcnt_nx;
  logic [1:0]       r_phase, w_phase_nx;
  logic [3:0]       r_bit, w_bit_nx;
  logic             r_step, w_step_nx;

  logic             r_bop, r_cgp, r_cgpn, r_cgq, r_cgqn, r_cgr, r_cgrn;
  logic             r_wend, r_running, r_halted;
  logic             w_bop, w_wend;
  logic [2:0]       w_pat;

  logic             w_mismatch, w_fault;

`ifdef PHASE_MON_EN
  logic r_fault, r_ph_new;
  // feedback is allowed one settling cycle after every phase change
  assign w_mismatch = (r_state == S_RUN) && !r_ph_new && (PH_FB != (4'b0001 << r_phase));
  assign w_fault    = r_fault;
  assign CLK_FAULT  = r_fault;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_fault  <= 1'b0;
      r_ph_new <= 1'b0;
    end else begin
      if (w_state_nx == S_OFF) r_fault <= 1'b0;
      else if (w_mismatch)     r_fault <= 1'b1;
      r_ph_new <= (w_state_nx == S_RUN) && ((r_state != S_RUN) || (w_phase_nx != r_phase));
    end
  end
`else
  assign w_mismatch = 1'b0;
  assign w_fault    = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_OFF;
      r_pcnt    <= '0;
      r_wcnt    <= '0;
      r_phase   <= 2'd0;
      r_bit     <= 4'd0;
      r_step    <= 1'b0;
      r_bop     <= 1'b0;
      r_cgp     <= 1'b0;
      r_cgq     <= 1'b0;
      r_cgr     <= 1'b0;
      r_cgpn    <= 1'b1;
      r_cgqn    <= 1'b1;
      r_cgrn    <= 1'b1;
      r_wend    <= 1'b0;
      r_running <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_pcnt    <= w_pcnt_nx;
      r_wcnt    <= w_wcnt_nx;
      r_phase   <= w_phase_nx;
      r_bit     <= w_bit_nx;
      r_step    <= w_step_nx;
      r_bop     <= w_bop;
      r_cgp     <= w_pat[2];
      r_cgq     <= w_pat[1];
      r_cgr     <= w_pat[0];
      r_cgpn    <= ~w_pat[2];
      r_cgqn    <= ~w_pat[1];
      r_cgrn    <= ~w_pat[0];
      r_wend    <= w_wend;
      r_running <= (w_state_nx == S_RUN);
      r_halted  <= (w_state_nx == S_HALT);
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    w_pcnt_nx  = r_pcnt;
    w_wcnt_nx  = r_wcnt;
    w_phase_nx = r_phase;
    w_bit_nx   = r_bit;
    w_step_nx  = r_step;
    case (r_state)
      S_OFF: begin
        w_pcnt_nx  = '0;
        w_wcnt_nx  = '0;
        w_phase_nx = 2'd0;
        w_bit_nx   = 4'd0;
        w_step_nx  = 1'b0;
        if (ENABLE) w_state_nx = S_WARMUP;
      end
      S_WARMUP: begin
        if (r_wcnt == WC_LAST) begin
          w_state_nx = S_HALT;
          w_wcnt_nx  = '0;
        end else begin
          w_wcnt_nx  = r_wcnt + 1'b1;
        end
      end
      S_HALT: begin
        w_pcnt_nx  = '0;
        w_phase_nx = 2'd0;
        w_bit_nx   = 4'd0;
        if ((RUN_REQ || STEP) && !w_fault) begin
          w_state_nx = S_RUN;
          w_step_nx  = STEP;
        end
      end
      S_RUN: begin
        if (r_pcnt == PC_LAST) begin
          w_pcnt_nx  = '0;
          w_phase_nx = r_phase + 2'd1;
          if (r_phase == 2'd3) begin
            if (r_bit == BIT_LAST) begin
              w_bit_nx = 4'd0;
              if (r_step || !RUN_REQ) begin
                w_state_nx = S_HALT;
                w_step_nx  = 1'b0;
              end
            end else begin
              w_bit_nx = r_bit + 4'd1;
            end
          end
        end else begin
          w_pcnt_nx = r_pcnt + 1'b1;
        end
        if (w_mismatch) begin
          w_state_nx = S_HALT;
          w_pcnt_nx  = '0;
          w_phase_nx = 2'd0;
          w_bit_nx   = 4'd0;
          w_step_nx  = 1'b0;
        end
      end
      default: w_state_nx = S_OFF;
    endcase
    // power loss aborts anything, mid-word included
    if (!ENABLE) begin
      w_state_nx = S_OFF;
      w_pcnt_nx  = '0;
      w_wcnt_nx  = '0;
      w_phase_nx = 2'd0;
      w_bit_nx   = 4'd0;
      w_step_nx  = 1'b0;
    end
  end

  // Output logic, evaluated on next-state values so the registered outputs track the state
  always_comb begin
    w_bop  = 1'b0;
    w_pat  = 3'b000;
    w_wend = 1'b0;
    case (w_state_nx)
      S_WARMUP, S_HALT: w_pat = 3'b101;
      S_RUN: begin
        w_bop  = 1'b1;
        w_pat  = f_pattern(w_phase_nx);
        w_wend = (w_phase_nx == 2'd3) && (w_pcnt_nx == PC_LAST) && (w_bit_nx == BIT_LAST);
      end
      default: w_pat = 3'b000;
    endcase
  end

  assign BOP      = r_bop;
  assign CGPP     = r_cgp;
  assign CGPPN    = r_cgpn;
  assign CGQP     = r_cgq;
  assign CGQPN    = r_cgqn;
  assign CGRP     = r_cgr;
  assign CGRPN    = r_cgrn;
  assign PHASE    = r_phase;
  assign BIT_TIME = r_bit;
  assign WORD_END = r_wend;
  assign RUNNING  = r_running;
  assign HALTED   = r_halted;

endmodule

// File: tb/tb_timing_sequencer.sv
// Bench for timing_sequencer: directed scenarios plus random ENABLE/RUN_REQ/STEP/RESET,
// every cycle compared against a word-position model (mode + cycle index within the word).
module tb_timing_sequencer;
  localparam int PC  = 2;
  localparam int BPW = 14;
  localparam int SC  = 16;
  localparam int WL  = 4 * PC * BPW;

  logic CLK = 1'b0;
  logic RESET, ENABLE, RUN_REQ, STEP;
  logic BOP, CGPP, CGPPN, CGQP, CGQPN, CGRP, CGRPN;
  logic [1:0] PHASE;
  logic [3:0] BIT_TIME;
  logic WORD_END, RUNNING, HALTED;
`ifdef PHASE_MON_EN
  logic [3:0] PH_FB;
  logic CLK_FAULT;
  assign PH_FB = 4'b0001 << PHASE;
`endif

  timing_sequencer #(.PHASE_CYCLES(PC), .BITS_PER_WORD(BPW), .STARTUP_CYCLES(SC)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .RUN_REQ(RUN_REQ), .STEP(STEP),
`ifdef PHASE_MON_EN
    .PH_FB(PH_FB), .CLK_FAULT(CLK_FAULT),
`endif
    .BOP(BOP), .CGPP(CGPP), .CGPPN(CGPPN), .CGQP(CGQP), .CGQPN(CGQPN),
    .CGRP(CGRP), .CGRPN(CGRPN), .PHASE(PHASE), .BIT_TIME(BIT_TIME),
    .WORD_END(WORD_END), .RUNNING(RUNNING), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: mode 0=off 1=warmup 2=halt 3=run; t = cycle index inside the running word
  int m_mode = 0, m_wc = 0, m_t = 0;
  bit m_step = 0, m_valid = 0;

  always @(posedge CLK) begin
    if (RESET) begin
      m_mode = 0; m_wc = 0; m_t = 0; m_step = 0; m_valid = 1;
    end else if (!ENABLE) begin
      m_mode = 0; m_wc = 0; m_t = 0; m_step = 0;
    end else begin
      case (m_mode)
        0: begin m_mode = 1; m_wc = 0; end
        1: if (m_wc == SC - 1) m_mode = 2; else m_wc++;
        2: if (RUN_REQ || STEP) begin m_mode = 3; m_t = 0; m_step = STEP; end
        default: begin
          if (m_t == WL - 1) begin
            if (m_step || !RUN_REQ) begin m_mode = 2; m_step = 0; end
            m_t = 0;
          end else m_t++;
        end
      endcase
    end
  end

  function automatic logic [2:0] pat_of(input int ph);
    logic [11:0] tbl;
    tbl = 12'b101_011_110_000;
    pat_of = tbl[11 - 3*ph -: 3];
  endfunction

  // Every-cycle compare of the whole output vector
  always @(negedge CLK) begin
    if (m_valid) begin
      logic [16:0] exp_v, act_v;
      logic [2:0] p;
      int ph, bt;
      ph = (m_mode == 3) ? (m_t / PC) % 4 : 0;
      bt = (m_mode == 3) ? m_t / (4 * PC) : 0;
      p  = (m_mode == 0) ? 3'b000 : (m_mode == 3) ? pat_of(ph) : 3'b101;
      exp_v = {m_mode == 3, p[2], ~p[2], p[1], ~p[1], p[0], ~p[0], 2'(ph), 4'(bt),
               (m_mode == 3) && (m_t == WL - 1), m_mode == 3, m_mode == 2};
      act_v = {BOP, CGPP, CGPPN, CGQP, CGQPN, CGRP, CGRPN, PHASE, BIT_TIME, WORD_END, RUNNING, HALTED};
      chk("cycle", int'(act_v), int'(exp_v));
`ifdef PHASE_MON_EN
      chk("clk_fault", int'(CLK_FAULT), 0);
`endif
    end
  end

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_halted(input int budget);
    for (int i = 0; i < budget && !HALTED; i++) tick();
    chk("halt_timeout", int'(HALTED), 1);
  endtask

  initial begin
    int n, cyc, we_n, we_at;
    RESET = 1; ENABLE = 0; RUN_REQ = 0; STEP = 0;
    repeat (2) tick();
    RESET = 0;
    chk("rst_bop", int'(BOP), 0);
    chk("rst_gen", int'({CGPP, CGQP, CGRP}), 0);
    chk("rst_genn", int'({CGPPN, CGQPN, CGRPN}), 7);
    chk("rst_status", int'({RUNNING, HALTED, WORD_END}), 0);

    // Power-up: warmup length
    ENABLE = 1;
    n = 0;
    for (int i = 0; i < 100 && !HALTED; i++) begin
      tick();
      if (!HALTED && CGPP) n++;
    end
    chk("warmup_len", n, SC);
    chk("halt_pattern", int'({HALTED, BOP, CGPP, CGQP, CGRP}), 5'b10101);

    // Single-word step
    STEP = 1; tick(); STEP = 0;
    cyc = 0; we_n = 0; we_at = 0;
    for (int i = 0; i < 400; i++) begin
      if (RUNNING) begin
        cyc++;
        if (WORD_END) begin we_n++; we_at = cyc; end
        if (cyc == 5) chk("step_c5", int'({PHASE, CGPP, CGQP, CGRP}), 5'b10_110);
        if (cyc == 9) chk("step_c9", int'({BIT_TIME, PHASE}), 6'b0001_00);
      end
      if (HALTED) break;
      tick();
    end
    chk("step_len", cyc, 112);
    chk("step_we_n", we_n, 1);
    chk("step_we_at", we_at, 112);
    chk("step_end", int'({HALTED, BIT_TIME}), 5'b1_0000);

    // Continuous run, drop RUN_REQ mid word 4
    RUN_REQ = 1; we_n = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (WORD_END) we_n++;
      if (we_n == 3 && BIT_TIME == 4'd5) break;
    end
    RUN_REQ = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (WORD_END) we_n++;
      if (HALTED) break;
    end
    chk("run_we_n", we_n, 4);
    chk("run_halted", int'(HALTED), 1);

    // Abort during phase Y of bit 7
    RUN_REQ = 1;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (RUNNING && BIT_TIME == 4'd7 && PHASE == 2'd2) break;
    end
    chk("abort_pos", int'({RUNNING, BIT_TIME, PHASE}), 7'b1_0111_10);
    ENABLE = 0; tick(); RUN_REQ = 0;
    chk("abort_off", int'({RUNNING, HALTED, BOP, CGPP, CGQP, CGRP, PHASE, BIT_TIME}), 0);
    chk("abort_genn", int'({CGPPN, CGQPN, CGRPN}), 7);
    ENABLE = 1;
    wait_halted(100);

    // Random traffic against the model
    for (int i = 0; i < 5000; i++) begin
      tick();
      RESET  = ($urandom_range(0, 999) == 0);
      ENABLE = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 149) == 0) RUN_REQ = ~RUN_REQ;
      STEP   = ($urandom_range(0, 24) == 0);
    end
    RESET = 0; STEP = 0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
